// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with GF(2^m) XOR mode.
// One BLOCK_WIDTH lookahead group per stage; global stall on output backpressure.
module cla_adder_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic                  cin,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   sum,
    output logic                  ovf
);

    localparam int NUM_BLK = DATA_WIDTH / BLOCK_WIDTH;
    localparam int BW      = BLOCK_WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_GF  = 2'b11;

    logic en;
    logic ovf_q;

    assign in_ready = !out_valid || out_ready;
    assign en       = in_ready;

    genvar k;
    generate
        for (k = 0; k < NUM_BLK; k++) begin : g_stg
            localparam int LO = k * BW;
            localparam int HI = (k + 1) * BW;

            logic [BW-1:0] a_grp, b_raw, b_grp, g, p, s;
            logic [1:0]    op_in;
            logic          c_in, v_in;
            logic [BW:0]   c;
            logic [HI-1:0] res_next, res_q;
            logic          v_q, c_q;

            if (k == 0) begin : g_in
                assign a_grp    = a[BW-1:0];
                assign b_raw    = b[BW-1:0];
                assign op_in    = op;
                assign v_in     = in_valid;
                assign c_in     = (op == OP_ADC) ? cin : (op == OP_SUB);
                assign res_next = s;
            end else begin : g_in
                assign a_grp    = g_stg[k-1].g_skew.ah_q[BW-1:0];
                assign b_raw    = g_stg[k-1].g_skew.bh_q[BW-1:0];
                assign op_in    = g_stg[k-1].g_skew.op_q;
                assign v_in     = g_stg[k-1].v_q;
                assign c_in     = g_stg[k-1].c_q;
                assign res_next = {s, g_stg[k-1].res_q};
            end

            assign b_grp = (op_in == OP_SUB) ? ~b_raw : b_raw;

            // GF mode kills every carry, so the group sum collapses to a ^ b
            always_comb begin
                g    = a_grp & b_grp;
                p    = a_grp | b_grp;
                c    = '0;
                c[0] = c_in;
                for (int i = 0; i < BW; i++) begin
                    c[i+1] = (op_in != OP_GF) & (g[i] | (p[i] & c[i]));
                end
                s = a_grp ^ b_grp ^ c[BW-1:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    res_q <= '0;
                end else if (en) begin
                    v_q   <= v_in;
                    c_q   <= c[BW];
                    res_q <= res_next;
                end
            end

            if (k < NUM_BLK - 1) begin : g_skew
                logic [DATA_WIDTH-HI-1:0] ah_q, bh_q, ah_next, bh_next;
                logic [1:0]               op_q;

                if (k == 0) begin : g_src
                    assign ah_next = a[DATA_WIDTH-1:HI];
                    assign bh_next = b[DATA_WIDTH-1:HI];
                end else begin : g_src
                    assign ah_next = g_stg[k-1].g_skew.ah_q[DATA_WIDTH-LO-1:BW];
                    assign bh_next = g_stg[k-1].g_skew.bh_q[DATA_WIDTH-LO-1:BW];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ah_q <= '0;
                        bh_q <= '0;
                        op_q <= OP_ADD;
                    end else if (en) begin
                        ah_q <= ah_next;
                        bh_q <= bh_next;
                        op_q <= op_in;
                    end
                end
            end
        end
    endgenerate

    // Overflow is the MSB carry-in XOR carry-out of the final group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= g_stg[NUM_BLK-1].c[BW] ^ g_stg[NUM_BLK-1].c[BW-1];
        end
    end

    assign out_valid = g_stg[NUM_BLK-1].v_q;
    assign sum       = {g_stg[NUM_BLK-1].c_q, g_stg[NUM_BLK-1].res_q};
    assign ovf       = ovf_q;

endmodule
